// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-to-memory sequencing front-end.
package mem_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int MEM_DEPTH = 500;
    localparam int MAX_WAIT  = 15;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request/response handshake plus the memory strobe bus, as seen by mem_ctrl.
interface mem_ctrl_if;
    import mem_pkg::*;

    logic  req;
    logic  wr;
    word_t cpu_addr;
    word_t cpu_wdata;
    logic  busy;
    logic  done;
    logic  err;
    word_t rdata;
    word_t mem_addr;
    word_t mem_datain;
    logic  mem_re;
    logic  mem_we;
    word_t mem_dataout;

    modport master (
        output req, wr, cpu_addr, cpu_wdata, mem_dataout,
        input  busy, done, err, rdata, mem_addr, mem_datain, mem_re, mem_we
    );

    modport slave (
        input  req, wr, cpu_addr, cpu_wdata, mem_dataout,
        output busy, done, err, rdata, mem_addr, mem_datain, mem_re, mem_we
    );

endinterface

// File: rtl/mem_ctrl.sv
// Single-request load/store sequencer: latches a CPU request, holds the memory
// strobe for WAIT_CYCLES cycles, captures load data and reports done/err.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_ctrl_if.slave  bus
);

    localparam logic [3:0] LOAD_CNT = 4'(WAIT_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_count;
    word_t      r_addr;
    word_t      r_wdata;
    logic       r_wr;
    logic       r_err;
    word_t      r_rdata;
    logic       w_in_range;

    // Widen before comparing so 16'hFFFF can never alias into range.
    assign w_in_range = 32'(bus.cpu_addr) < DEPTH;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.req) w_next_state = w_in_range ? ACCESS : RESP;
            ACCESS:  if (r_count == 4'd0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        if (w_in_range) begin
                            r_addr  <= bus.cpu_addr;
                            r_wdata <= bus.cpu_wdata;
                            r_wr    <= bus.wr;
                            r_count <= LOAD_CNT;
                            r_err   <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd0 && !r_wr) r_rdata <= bus.mem_dataout;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from registered state only, so re and we stay exclusive.
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == RESP);
    assign bus.err        = (r_state == RESP) && r_err;
    assign bus.mem_re     = (r_state == ACCESS) && !r_wr;
    assign bus.mem_we     = (r_state == ACCESS) && r_wr;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_datain = r_wdata;
    assign bus.rdata      = r_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: two instances (WAIT_CYCLES=1 and 3), each
// beside a behavioural word memory; a negedge monitor checks every done pulse.
module tb_mem_ctrl;
    import mem_pkg::*;

    typedef struct {
        logic  err;
        word_t rdata;
        int    cyc;
        int    n_re;
        int    n_we;
    } exp_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    logic init_mem = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    word_t mem1 [512];
    word_t mem3 [512];
    int    re_run3 = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   n_re [2];
    int   n_we [2];
    logic prev_done [2];

    mem_ctrl_if if1();
    mem_ctrl_if if3();

    mem_ctrl #(.DEPTH(500), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(rst1), .bus(if1));
    mem_ctrl #(.DEPTH(500), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(rst3), .bus(if3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The WAIT_CYCLES=3 memory adds the strobe-cycle index to its data, so the
    // captured value reveals which strobe cycle was sampled.
    assign if1.mem_dataout = if1.mem_re ? mem1[if1.mem_addr[8:0]] : 16'h0000;
    assign if3.mem_dataout = if3.mem_re ? mem3[if3.mem_addr[8:0]] + 16'(re_run3) : 16'h0000;

    // Word i preloads as 16'h1000 + i; writes commit on any edge with we high.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 512; i++) begin
                mem1[i] <= 16'h1000 + 16'(i);
                mem3[i] <= 16'h1000 + 16'(i);
            end
            re_run3 <= 0;
        end else begin
            if (if1.mem_we === 1'b1) mem1[if1.mem_addr[8:0]] <= if1.mem_datain;
            if (if3.mem_we === 1'b1) mem3[if3.mem_addr[8:0]] <= if3.mem_datain;
            re_run3 <= (if3.mem_re === 1'b1) ? re_run3 + 1 : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic rst, input logic done, input logic err,
                       input logic re, input logic we, input word_t rd);
        exp_t e;
        if (rst) begin
            n_re[k] = 0;
            n_we[k] = 0;
            prev_done[k] = 1'b0;
            return;
        end
        check($sformatf("re_we_exclusive%0d", k), {31'b0, re & we}, 0);
        check($sformatf("done_single%0d", k), {31'b0, done & prev_done[k]}, 0);
        if (re) n_re[k]++;
        if (we) n_we[k]++;
        if (done === 1'b1) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done%0d: got done at cycle %0d expected none", k, cyc);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("err%0d", k), {31'b0, err}, {31'b0, e.err});
                check($sformatf("rdata%0d", k), {16'b0, rd}, {16'b0, e.rdata});
                check($sformatf("done_cycle%0d", k), cyc, e.cyc);
                check($sformatf("re_cycles%0d", k), n_re[k], e.n_re);
                check($sformatf("we_cycles%0d", k), n_we[k], e.n_we);
            end
            n_re[k] = 0;
            n_we[k] = 0;
        end
        prev_done[k] = done;
    endtask

    always @(negedge clk) begin
        mon(0, rst1, if1.done, if1.err, if1.mem_re, if1.mem_we, if1.rdata);
        mon(1, rst3, if3.done, if3.err, if3.mem_re, if3.mem_we, if3.rdata);
    end

    task automatic drive(input int k, input logic r, input logic w, input word_t a, input word_t d);
        if (k == 0) begin
            if1.req = r; if1.wr = w; if1.cpu_addr = a; if1.cpu_wdata = d;
        end else begin
            if3.req = r; if3.wr = w; if3.cpu_addr = a; if3.cpu_wdata = d;
        end
    endtask

    // Expected done cycle: error at +1, good access at WAIT_CYCLES+1 after the sampling edge.
    task automatic push_exp(input int k, input logic w, input word_t exp_rd, input logic exp_err);
        exp_t e;
        int   wc;
        wc      = (k == 0) ? 1 : 3;
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.cyc   = cyc + (exp_err ? 1 : wc + 1);
        e.n_re  = (!exp_err && !w) ? wc : 0;
        e.n_we  = (!exp_err && w) ? wc : 0;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_drain(input int k);
        for (int i = 0; i < 20 && (k == 0 ? q0.size() : q1.size()) != 0; i++) @(negedge clk);
        if ((k == 0 ? q0.size() : q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout%0d: got no done within 20 cycles expected a done pulse", k);
            if (k == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    task automatic issue(input int k, input logic w, input word_t a, input word_t d,
                         input word_t exp_rd, input logic exp_err);
        @(negedge clk);
        drive(k, 1'b1, w, a, d);
        push_exp(k, w, exp_rd, exp_err);
        @(negedge clk);
        drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_drain(k);
    endtask

    task automatic check_zero(input int k);
        if (k == 0) begin
            check("rst_busy", {31'b0, if1.busy}, 0);
            check("rst_done", {31'b0, if1.done}, 0);
            check("rst_err", {31'b0, if1.err}, 0);
            check("rst_strobes", {30'b0, if1.mem_re, if1.mem_we}, 0);
            check("rst_addr_data", {if1.mem_addr, if1.mem_datain}, 0);
            check("rst_rdata", {16'b0, if1.rdata}, 0);
        end else begin
            check("rst3_busy_done", {30'b0, if3.busy, if3.done}, 0);
            check("rst3_strobes", {30'b0, if3.mem_re, if3.mem_we}, 0);
            check("rst3_rdata", {16'b0, if3.rdata}, 0);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        init_mem = 1'b0;
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Store then load, WAIT_CYCLES=1.
        issue(0, 1'b1, 16'd5, 16'hBEEF, 16'h0000, 1'b0);
        issue(0, 1'b0, 16'd5, 16'h0000, 16'hBEEF, 1'b0);

        // Range boundary.
        issue(0, 1'b1, 16'd499, 16'h1234, 16'hBEEF, 1'b0);
        issue(0, 1'b0, 16'd499, 16'h0000, 16'h1234, 1'b0);
        issue(0, 1'b0, 16'd500, 16'h0000, 16'h1234, 1'b1);
        issue(0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 1'b1);

        // Store to 7 presented during ACCESS and RESP of a load of 6 is ignored.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'd6, 16'h0000);
        push_exp(0, 1'b0, 16'h1006, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'd7, 16'hDEAD);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        wait_drain(0);
        repeat (3) @(negedge clk);
        check("busy_ignore_mem7", {16'b0, mem1[7]}, 32'h1007);
        check("busy_ignore_idle", {31'b0, if1.busy}, 0);

        // Reset during the ACCESS cycle of a store abandons it without done.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'd9, 16'hC0DE);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst1 = 1'b1;
        @(negedge clk);
        check_zero(0);
        @(negedge clk);
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        // The strobe cycle before reset already committed the word in the model.
        issue(0, 1'b0, 16'd9, 16'h0000, 16'hC0DE, 1'b0);

        // WAIT_CYCLES=3: data from the third strobe cycle is 16'h1000 + 2.
        issue(1, 1'b0, 16'd0, 16'h0000, 16'h1002, 1'b0);
        issue(1, 1'b0, 16'hFFFF, 16'h0000, 16'h1002, 1'b1);

        repeat (4) @(negedge clk);
        check("queue0_empty", q0.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sequencing front-end between the CPU datapath and the 16-bit word memory.
- Accepts one load/store request at a time over a req/done handshake and latches the address and write data.
- Drives the memory's addr/datain/re/we strobes for a programmable number of cycles, captures read data into a register, and reports completion or an out-of-range error.
- Guarantees re and we are never asserted together, so the memory's tri-state read output is never floated or contended.

Parameters:
- DEPTH, 500, number of implemented memory words; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 1, cycles the re/we strobe is held per access; legal range 1..15.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  1  CPU request strobe; sampled only in IDLE.
- wr  input  1  1 = store, 0 = load; sampled with req.
- cpu_addr  input  16  word address; sampled with req.
- cpu_wdata  input  16  store data; sampled with req.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = address out of range, no access performed.
- rdata  output  16  last successfully loaded word; held until the next successful load.
- mem_addr  output  16  address to the memory.
- mem_datain  output  16  write data to the memory.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_dataout  input  16  memory read data; combinational from mem_addr while mem_re is high.

Behaviour:
- Reset: state=IDLE, count=0, addr_q=0, wdata_q=0, wr_q=0, err_q=0, rdata=0. All outputs low/zero, including busy, done, err, mem_re, mem_we, mem_addr and mem_datain.
- Reset dominates all other inputs. Asserting it mid-access drops mem_re/mem_we at that edge and abandons the access; no done pulse is issued.
- FSM states: IDLE, ACCESS, RESP. All outputs decode from registered state only; no input-to-output combinational path.
- IDLE with req=1 and cpu_addr < DEPTH:
  - Latch cpu_addr, cpu_wdata and wr.
  - Set count=WAIT_CYCLES-1 and err_q=0.
  - Go to ACCESS.
- IDLE with req=1 and cpu_addr >= DEPTH:
  - Set err_q=1 and go to RESP.
  - No strobes are issued in this path.
- IDLE with req=0: stay in IDLE.
- ACCESS:
  - mem_addr=addr_q and mem_datain=wdata_q.
  - mem_re=~wr_q and mem_we=wr_q.
  - count decrements each cycle.
  - When count==0: for a load, rdata<=mem_dataout at that edge; then go to RESP.
- RESP: done=1 and err=err_q for exactly one cycle, then go to IDLE.
- mem_addr and mem_datain hold addr_q and wdata_q in all states. In IDLE after reset they are 0.
- Latency from the req-sampling edge:
  - Good access: done is high in cycle WAIT_CYCLES+1.
  - Error: done is high in cycle 1.
- req while busy=1 is ignored, not queued. The CPU must hold or re-present req after done.
- req high in the same cycle as done (RESP) is ignored. The earliest accepted back-to-back req is sampled in the IDLE cycle after done.
- Width rules:
  - The range compare uses the full 16-bit cpu_addr against DEPTH. 16'hFFFF is out of range, with no truncation or wrap.
  - count is 4 bits.
- rdata is not updated by stores or by errored loads.

Decomposition:
- Shared package mem_pkg holds:
  - typedef word_t (logic [15:0]).
  - enum state_t {IDLE, ACCESS, RESP}.
  - constants MEM_DEPTH=500 and MAX_WAIT=15.
- No sub-module; the FSM plus datapath registers are a single block.
- The existing memory is instantiated beside mem_ctrl at the top level, not inside it.

Test Plan:
- Store then load: store addr=5, data=16'hBEEF with WAIT_CYCLES=1, followed by a load of addr=5.
  - mem_we is high for 1 cycle and done is high at t+2 with err=0.
  - For the load, mem_re is high for 1 cycle and done is high at t+2 with rdata=16'hBEEF.
- Boundary: store and load at addr=499 (16'h1234) succeed with err=0. A load at addr=500 gives done at t+1 with err=1, mem_re/mem_we never high, and rdata unchanged at 16'h1234.
- WAIT_CYCLES=3: load addr=0.
  - mem_re is high for exactly 3 consecutive cycles and done is high at t+4.
  - rdata equals the word captured on the last strobe cycle.
- Busy ignore: issue a second req (store addr=7) during ACCESS and during RESP of a load at addr=6. Only the load happens, memory word 7 is unchanged, and exactly one done pulse is seen.
- Reset mid-op: assert reset in the ACCESS cycle of a store to addr=9.
  - At the next edge all outputs are 0 and the state is IDLE.
  - No done pulse is issued.
  - A subsequent load at addr=9 completes normally.
- Invariant across all tests: mem_re & mem_we is never 1, and done is never high for two consecutive cycles.
